// File: rtl/jtframe_kabuki_pkg.sv
// Shared definitions for the Kabuki key loader: FSM state encoding and key length.
package jtframe_kabuki_pkg;

  localparam int unsigned KABUKI_KEY_LEN = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_END = 3'd2,
    ST_READY    = 3'd3,
    ST_PLAIN    = 3'd4
  } kab_state_t;

endpackage

// File: rtl/jtframe_kabuki_keyload.sv
// Captures the 11-byte Kabuki key from the ROM download stream, shifts it into the
// decoder in address order and decides whether the decoder is enabled afterwards.
module jtframe_kabuki_keyload
  import jtframe_kabuki_pkg::*;
#(
  parameter logic [24:0] KEY_ADDR = 25'h0,
  parameter int unsigned KEY_LEN  = KABUKI_KEY_LEN
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic [7:0]  prog_data,
  output logic        prog_we,
  output logic        kabuki_en,
  output logic        key_err,
  output logic        cpu_rst
);

  localparam logic [3:0]  LAST_IDX = 4'(KEY_LEN - 1);
  localparam logic [24:0] LEN_25   = 25'(KEY_LEN);

  logic        r_wr_d;
  logic        r_dl_d;
  logic        r_ev;
  logic        r_rise;
  logic        r_fall;
  logic [24:0] r_addr;
  logic [7:0]  r_data;
  kab_state_t  r_state;
  logic [3:0]  r_cnt;
  logic [7:0]  r_zacc;

  logic [24:0] w_off;
  logic        w_inrange;
  logic [3:0]  w_cnt;
  logic        w_match;
  logic        w_loading;

  // A restart seen together with a write makes that write the first byte of the new key.
  always_comb begin
    w_off     = r_addr - KEY_ADDR;
    w_inrange = w_off < LEN_25;
    w_cnt     = r_rise ? '0 : r_cnt;
    w_match   = w_off[3:0] == w_cnt;
    w_loading = r_rise || (r_state == ST_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_d    <= 1'b0;
      r_dl_d    <= 1'b0;
      r_ev      <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_zacc    <= '0;
      prog_data <= '0;
      prog_we   <= 1'b0;
      kabuki_en <= 1'b0;
      key_err   <= 1'b0;
      cpu_rst   <= 1'b1;
    end else begin
      r_wr_d  <= ioctl_wr;
      r_dl_d  <= downloading;
      r_ev    <= ioctl_wr & ~r_wr_d & downloading;
      r_rise  <= downloading & ~r_dl_d;
      r_fall  <= ~downloading & r_dl_d;
      r_addr  <= ioctl_addr;
      r_data  <= ioctl_dout;
      prog_we <= 1'b0;

      if (r_rise) begin
        r_state   <= ST_LOAD;
        r_cnt     <= '0;
        r_zacc    <= '0;
        key_err   <= 1'b0;
        kabuki_en <= 1'b0;
        cpu_rst   <= 1'b1;
      end

      if (w_loading && r_ev && w_inrange) begin
        if (w_match) begin
          prog_data <= r_data;
          prog_we   <= 1'b1;
          r_cnt     <= w_cnt + 4'd1;
          r_zacc    <= (r_rise ? 8'h00 : r_zacc) | r_data;
          if (w_cnt == LAST_IDX) r_state <= ST_WAIT_END;
        end else begin
          key_err <= 1'b1;
        end
      end

      if (!r_rise && r_fall) begin
        case (r_state)
          ST_LOAD: begin
            r_state <= ST_PLAIN;
            key_err <= 1'b1;
            cpu_rst <= 1'b0;
          end
          ST_WAIT_END: begin
            if (r_zacc != '0 && !key_err) begin
              r_state   <= ST_READY;
              kabuki_en <= 1'b1;
            end else begin
              r_state <= ST_PLAIN;
            end
            cpu_rst <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_kabuki_keyload.sv
// Bench for the Kabuki key loader: directed key scenarios plus randomized downloads,
// checked every cycle against an event-level model of the key protocol.
module tb_jtframe_kabuki_keyload;

  localparam logic [24:0] KA = 25'h48000;

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [7:0]  prog_data;
  logic        prog_we;
  logic        kabuki_en;
  logic        key_err;
  logic        cpu_rst;

  jtframe_kabuki_keyload #(.KEY_ADDR(KA), .KEY_LEN(11)) dut (
    .rst(rst), .clk(clk), .downloading(downloading), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr), .prog_data(prog_data),
    .prog_we(prog_we), .kabuki_en(kabuki_en), .key_err(key_err), .cpu_rst(cpu_rst)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: protocol outcome of each clock's inputs, visible one clock later.
  localparam int P_IDLE = 0, P_LOAD = 1, P_WAIT = 2, P_READY = 3, P_PLAIN = 4;
  typedef struct {
    logic       we;
    logic [7:0] data;
    logic       en;
    logic       err;
    logic       crst;
  } exp_t;

  exp_t       exp_cur, exp_pend;
  int         m_phase;
  int         m_cnt;
  bit         m_nz, m_err, m_pwr, m_pdl, m_valid = 1'b0;
  logic [7:0] m_pdata;

  always @(posedge clk) begin
    bit rise, fall, ev, we;
    logic [24:0] off;
    if (rst) begin
      m_phase = P_IDLE; m_cnt = 0; m_nz = 0; m_err = 0; m_pwr = 0; m_pdl = 0;
      m_pdata = 8'h00; m_valid = 1'b1;
      exp_cur.we = 0; exp_cur.data = 8'h00; exp_cur.en = 0; exp_cur.err = 0; exp_cur.crst = 1;
      exp_pend = exp_cur;
    end else begin
      exp_cur = exp_pend;
      rise = downloading && !m_pdl;
      fall = !downloading && m_pdl;
      ev   = ioctl_wr && !m_pwr && downloading;
      we   = 0;
      if (rise) begin
        m_phase = P_LOAD; m_cnt = 0; m_nz = 0; m_err = 0;
      end
      if (ev && m_phase == P_LOAD) begin
        off = ioctl_addr - KA;
        if (off < 25'd11) begin
          if (int'(off) == m_cnt) begin
            we = 1; m_pdata = ioctl_dout; m_cnt++;
            if (ioctl_dout != 0) m_nz = 1;
            if (m_cnt == 11) m_phase = P_WAIT;
          end else begin
            m_err = 1;
          end
        end
      end
      if (fall && !rise) begin
        if (m_phase == P_LOAD) begin
          m_phase = P_PLAIN; m_err = 1;
        end else if (m_phase == P_WAIT) begin
          m_phase = (m_nz && !m_err) ? P_READY : P_PLAIN;
        end
      end
      m_pwr = ioctl_wr;
      m_pdl = downloading;
      exp_pend.we   = we;
      exp_pend.data = m_pdata;
      exp_pend.en   = (m_phase == P_READY);
      exp_pend.err  = m_err;
      exp_pend.crst = !(m_phase == P_READY || m_phase == P_PLAIN);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("prog_we",   prog_we,   exp_cur.we);
      chk("prog_data", prog_data, exp_cur.data);
      chk("kabuki_en", kabuki_en, exp_cur.en);
      chk("key_err",   key_err,   exp_cur.err);
      chk("cpu_rst",   cpu_rst,   exp_cur.crst);
    end
  end

  int unsigned n_pulse = 0;
  logic [7:0]  bytes_q[$];

  always @(negedge clk) begin
    if (m_valid && prog_we === 1'b1) begin
      n_pulse++;
      bytes_q.push_back(prog_data);
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wbyte(input logic [24:0] a, input logic [7:0] d, input int unsigned len);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick(len);
    ioctl_wr = 1'b0;
    tick(1 + $urandom_range(0, 2));
  endtask

  task automatic clr_mon;
    n_pulse = 0;
    bytes_q.delete();
  endtask

  task automatic dl_on;
    downloading = 1'b1;
    tick(2);
  endtask

  task automatic dl_off;
    downloading = 1'b0;
    tick(4);
  endtask

  task automatic full_key(input logic [7:0] base);
    for (int unsigned i = 0; i < 11; i++) wbyte(KA + 25'(i), base + 8'(i), 3);
  endtask

  initial begin
    int unsigned nb;
    bit zero_mode;
    logic [24:0] a;
    logic [7:0] d;

    rst = 1'b1; downloading = 1'b0; ioctl_addr = '0; ioctl_dout = '0; ioctl_wr = 1'b0;
    tick(3);
    chk("rst_prog_we",   prog_we,   1'b0);
    chk("rst_prog_data", prog_data, 8'h00);
    chk("rst_kabuki_en", kabuki_en, 1'b0);
    chk("rst_key_err",   key_err,   1'b0);
    chk("rst_cpu_rst",   cpu_rst,   1'b1);
    rst = 1'b0;
    tick(2);

    // In-order key 01..0B
    clr_mon(); dl_on(); full_key(8'h01);
    chk("s1_cpu_rst_loading", cpu_rst, 1'b1);
    dl_off();
    chk("s1_pulses", n_pulse, 11);
    for (int unsigned i = 0; i < 11; i++)
      chk("s1_byte", (bytes_q.size() > i) ? bytes_q[i] : 8'hxx, 8'(i + 1));
    chk("s1_kabuki_en", kabuki_en, 1'b1);
    chk("s1_cpu_rst",   cpu_rst,   1'b0);
    chk("s1_key_err",   key_err,   1'b0);

    // All-zero key
    clr_mon(); dl_on(); full_key(8'h00);
    for (int unsigned i = 0; i < 11; i++) ;
    clr_mon(); dl_off(); dl_on();
    for (int unsigned i = 0; i < 11; i++) wbyte(KA + 25'(i), 8'h00, 2);
    dl_off();
    chk("s2_pulses",    n_pulse,   11);
    chk("s2_kabuki_en", kabuki_en, 1'b0);
    chk("s2_cpu_rst",   cpu_rst,   1'b0);
    chk("s2_key_err",   key_err,   1'b0);

    // Truncated key
    clr_mon(); dl_on();
    for (int unsigned i = 0; i < 6; i++) wbyte(KA + 25'(i), 8'h20 + 8'(i), 2);
    dl_off();
    chk("s3_pulses",    n_pulse,   6);
    chk("s3_key_err",   key_err,   1'b1);
    chk("s3_kabuki_en", kabuki_en, 1'b0);
    chk("s3_cpu_rst",   cpu_rst,   1'b0);

    // Offset 3 before offset 2
    clr_mon(); dl_on();
    wbyte(KA + 25'd0, 8'h10, 2);
    wbyte(KA + 25'd1, 8'h11, 2);
    wbyte(KA + 25'd3, 8'h13, 2);
    chk("s4_err_early", key_err, 1'b1);
    chk("s4_pulses_early", n_pulse, 2);
    for (int unsigned i = 2; i < 11; i++) wbyte(KA + 25'(i), 8'h10 + 8'(i), 2);
    dl_off();
    chk("s4_pulses",    n_pulse,   11);
    chk("s4_key_err",   key_err,   1'b1);
    chk("s4_kabuki_en", kabuki_en, 1'b0);

    // Out-of-range addresses and a 12th write
    clr_mon(); dl_on();
    wbyte(25'h47FFF, 8'hAA, 2);
    wbyte(25'h4800B, 8'hBB, 2);
    chk("s5_oor_pulses", n_pulse, 0);
    full_key(8'h31);
    wbyte(KA, 8'hCC, 2);
    wbyte(KA + 25'd10, 8'hDD, 2);
    dl_off();
    chk("s5_pulses",    n_pulse,   11);
    chk("s5_key_err",   key_err,   1'b0);
    chk("s5_kabuki_en", kabuki_en, 1'b1);

    // Reset mid-load, then a full reload
    dl_on();
    for (int unsigned i = 0; i < 5; i++) wbyte(KA + 25'(i), 8'h40 + 8'(i), 2);
    rst = 1'b1; downloading = 1'b0;
    tick(3);
    chk("s6_rst_en", kabuki_en, 1'b0);
    rst = 1'b0;
    tick(2);
    clr_mon(); dl_on(); full_key(8'h51); dl_off();
    chk("s6_pulses",    n_pulse,   11);
    chk("s6_kabuki_en", kabuki_en, 1'b1);
    downloading = 1'b1;
    tick(2);
    chk("s6_restart_en", kabuki_en, 1'b0);
    chk("s6_restart_cpu_rst", cpu_rst, 1'b1);
    dl_off();

    // Restart and first write on the same clock
    clr_mon();
    ioctl_addr = KA; ioctl_dout = 8'h5A; ioctl_wr = 1'b1; downloading = 1'b1;
    tick(3);
    ioctl_wr = 1'b0;
    tick(1);
    for (int unsigned i = 1; i < 11; i++) wbyte(KA + 25'(i), 8'h60 + 8'(i), 1);
    dl_off();
    chk("s7_pulses",     n_pulse, 11);
    chk("s7_first_byte", (bytes_q.size() > 0) ? bytes_q[0] : 8'hxx, 8'h5A);
    chk("s7_kabuki_en",  kabuki_en, 1'b1);

    // Randomized downloads
    for (int unsigned t = 0; t < 40; t++) begin
      zero_mode = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        ioctl_addr = KA; ioctl_dout = zero_mode ? 8'h00 : 8'($urandom);
        ioctl_wr = 1'b1; downloading = 1'b1;
        tick($urandom_range(1, 4));
        ioctl_wr = 1'b0;
        tick(1);
      end else begin
        downloading = 1'b1;
        tick($urandom_range(1, 3));
      end
      nb = $urandom_range(0, 13);
      for (int unsigned i = 0; i < nb; i++) begin
        if ($urandom_range(0, 5) == 0) a = KA - 25'd2 + 25'($urandom_range(0, 15));
        else a = KA + 25'(i);
        d = zero_mode ? 8'h00 : 8'($urandom);
        wbyte(a, d, $urandom_range(1, 4));
        if ($urandom_range(0, 40) == 0) begin
          rst = 1'b1; downloading = 1'b0;
          tick(2);
          rst = 1'b0;
        end
      end
      downloading = 1'b0;
      tick($urandom_range(3, 6));
    end

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
